chunked_add_sub: RTL and testbench
==================================

Name: chunked_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the fixed 4-bit ripple-carry adder.
- Computes A+B+cin or A−B−cin on WIDTH-bit operands, CHUNK bits per clock, LSB chunk first.
- Trades latency for a short carry chain. Start/busy/done handshake for use by datapath controllers.
- Adds subtract mode, signed-overflow detection and registered, held results.

Parameters:
WIDTH, 16, operand/result width; must be an integer multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH. CHUNK==WIDTH gives single-pass operation.
(derived) NCHUNK = WIDTH/CHUNK; chunk counter width = max(1, clog2(NCHUNK)).

Ports:
clk    input   1      rising-edge clock, single clock domain
rst    input   1      synchronous reset, active-high
start  input   1      request; sampled only in IDLE
sub    input   1      0: A+B+cin; 1: A−B−cin; sampled with start
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
cin    input   1      carry-in (add) / borrow-in (sub); sampled with start
busy   output  1      1 while state==RUN
done   output  1      one-cycle pulse when sum/cout/ovf become valid
sum    output  WIDTH  registered result; holds until next completion
cout   output  1      carry out of MSB. In sub mode 1 = no borrow, 0 = borrow.
ovf    output  1      signed (two's-complement) overflow of the completed operation

Behaviour:
- Reset: rst sampled high forces the following, with rst priority over everything, including start in the same cycle:
  - state=IDLE, chunk counter=0;
  - busy=0, done=0, sum=0, cout=0, ovf=0;
  - internal operand, carry and partial-sum registers cleared.
- States: IDLE and RUN.
- IDLE:
  - start=1 latches a_r=a and b_r=(sub ? ~b : b).
  - Carry register initialised to cin XOR sub, so sub computes A + ~B + !cin.
  - Counter set to 0; go to RUN.
  - start=0: stay in IDLE, outputs hold.
- RUN, each cycle for chunk k = counter:
  - partial[k*CHUNK +: CHUNK] = a_r chunk + b_r chunk + carry.
  - Carry register takes that chunk's carry-out; counter increments.
- RUN, last chunk (k==NCHUNK−1):
  - sum <= full partial result including this chunk.
  - cout <= carry out of bit WIDTH−1.
  - ovf <= carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - done <= 1; state <= IDLE; counter <= 0.
- done is high for exactly one cycle, the first IDLE cycle after RUN, and is cleared on the next edge.
- Latency:
  - start sampled at edge E0; chunks processed at edges E1..E_NCHUNK; done=1 in the cycle after E_NCHUNK.
  - Throughput: one operation per NCHUNK+1 cycles. start asserted in the done cycle is accepted (back-to-back).
- Input sampling:
  - start during RUN is ignored and not queued.
  - a, b, sub and cin changing during RUN have no effect.
- sum, cout and ovf change only at completion. Intermediate chunk results are never visible on sum.
- Arithmetic is modulo 2^WIDTH. No saturation. Each chunk carry chain is pure combinational ripple within the chunk.
- Reset mid-RUN: the operation is abandoned, no done pulse is produced, and outputs go to their reset values.

Test Plan:
- WIDTH=16, CHUNK=4, add:
  - a=0x1234, b=0x0FFF, cin=0, sub=0 -> sum=0x2233, cout=0, ovf=0.
  - busy high for exactly 4 cycles; done pulses once, 4 cycles after the start edge.
- Carry and overflow edges:
  - 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0xFFFF+0x0000 with cin=1 -> sum=0x0000, cout=1.
- Subtract:
  - 0x0005−0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0.
  - 0x8000−0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x0010−0x0001 with cin=1 -> sum=0x000E.
- Handshake:
  - start re-pulsed with new operands during RUN -> ignored; the result matches the first operands.
  - start held high in the done cycle -> second operation starts and completes with no idle gap.
- Reset:
  - rst asserted in the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse afterwards.
  - rst and start high together -> stays IDLE.
- Parameter sweep, for CHUNK=16, 1 and 8 (WIDTH=16):
  - CHUNK=16: done 1 cycle after start.
  - CHUNK=1: done 16 cycles after start.
  - CHUNK=8: same random vectors -> results identical to a reference A±B±cin model.

Source files
------------

// File: rtl/chunked_add_sub_if.sv
// Operand/result bundle for the multi-cycle adder/subtractor.
// The controller drives the master side and the arithmetic unit sits on the slave side.
interface chunked_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples CHUNK bits per clock, LSB chunk first.
// Results are registered and held until the next operation completes.
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  chunked_add_sub_if.slave bus,
  output logic             state_dbg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Handshake: start is honoured only while IDLE (busy=0); operands, sub and
  // cin are captured on that same edge. busy stays high for NCHUNK cycles,
  // then done pulses for one cycle with sum/cout/ovf already valid. A start
  // presented in the done cycle is accepted; a start during busy is dropped.

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            load;
  logic            step;
  logic            finish;

  // acc_r starts as operand A; each step shifts out the consumed chunk and
  // shifts in the corresponding result chunk at the top, so after the last
  // step it holds the complete sum.
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] b_next;
  logic [CHUNK:0]   chunk_add;
  logic             carry_into_msb;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             done_r;

  assign last = (cnt == LAST_CHUNK);

  // One CHUNK-wide ripple add per cycle on the low chunk of the shift registers.
  assign chunk_add = {1'b0, acc_r[CHUNK-1:0]}
                   + {1'b0, b_r[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_r};

  // Only meaningful on the last step, where the low chunk is the operand MSB chunk.
  assign carry_into_msb = acc_r[CHUNK-1] ^ b_r[CHUNK-1] ^ chunk_add[CHUNK-1];

  generate
    if (NCHUNK > 1) begin : g_multi
      assign acc_next = {chunk_add[CHUNK-1:0], acc_r[WIDTH-1:CHUNK]};
      assign b_next   = {{CHUNK{1'b0}}, b_r[WIDTH-1:CHUNK]};
    end else begin : g_single
      assign acc_next = chunk_add[CHUNK-1:0];
      assign b_next   = b_r;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc_r   <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load) begin
        // Subtract is A + ~B + !cin; the carry register absorbs the inversion of cin.
        acc_r   <= bus.a;
        b_r     <= bus.sub ? ~bus.b : bus.b;
        carry_r <= bus.cin ^ bus.sub;
        cnt     <= '0;
      end else if (step) begin
        acc_r   <= acc_next;
        b_r     <= b_next;
        carry_r <= chunk_add[CHUNK];
        if (finish) begin
          cnt    <= '0;
          sum_r  <= acc_next;
          cout_r <= chunk_add[CHUNK];
          ovf_r  <= carry_into_msb ^ chunk_add[CHUNK];
          done_r <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub: four instances (CHUNK = 4, 16, 1, 8) on WIDTH=16,
// results checked through an expected-result queue as each done pulse appears.
module tb_chunked_add_sub;

  localparam int W = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  start_v;
  logic        sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic        cin;

  logic [3:0]   busy_v;
  logic [3:0]   done_v;
  logic [3:0]   cout_v;
  logic [3:0]   ovf_v;
  logic [3:0]   dbg_v;
  logic [W-1:0] sum_v [4];

  int n_cmp;
  int n_err;

  // {instance[1:0], sum[15:0], cout, ovf}
  logic [19:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : (g == 1) ? 16 : (g == 2) ? 1 : 8;
    chunked_add_sub_if #(.WIDTH(W)) bus ();

    assign bus.start = start_v[g];
    assign bus.sub   = sub;
    assign bus.a     = a;
    assign bus.b     = b;
    assign bus.cin   = cin;

    chunked_add_sub #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .state_dbg (dbg_v[g])
    );

    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign cout_v[g] = bus.cout;
    assign ovf_v[g]  = bus.ovf;
    assign sum_v[g]  = bus.sum;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] model(input logic sb, input logic [W-1:0] aa,
                                        input logic [W-1:0] bb, input logic cc);
    logic [W:0] r;
    logic       v;
    if (!sb) begin
      r = {1'b0, aa} + {1'b0, bb} + 17'(cc);
      v = (aa[W-1] == bb[W-1]) && (r[W-1] != aa[W-1]);
      return {r[W-1:0], r[W], v};
    end else begin
      r = {1'b0, aa} - {1'b0, bb} - 17'(cc);
      v = (aa[W-1] != bb[W-1]) && (r[W-1] != aa[W-1]);
      return {r[W-1:0], ~r[W], v};
    end
  endfunction

  function automatic int lat_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      2:       return 16;
      default: return 2;
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin : scoreboard
    logic [19:0] e;
    for (int i = 0; i < 4; i++) begin
      if (done_v[i]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("done_expected_%0d", i), exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("done_inst", i, {30'd0, e[19:18]});
          check($sformatf("sum_%0d", i), sum_v[i], {16'd0, e[17:2]});
          check($sformatf("cout_%0d", i), cout_v[i], {31'd0, e[1]});
          check($sformatf("ovf_%0d", i), ovf_v[i], {31'd0, e[0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input logic sb, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic cc);
    sub = sb;
    a   = aa;
    b   = bb;
    cin = cc;
  endtask

  // Called at a negedge with the instance idle; returns at the negedge after done.
  task automatic run_op(input int idx, input logic sb, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic cc, input logic [17:0] exp_res);
    int lat;
    int busy_cnt;
    exp_q.push_back({2'(idx), exp_res});
    set_ops(sb, aa, bb, cc);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v = '0;
    lat = 0;
    busy_cnt = 0;
    while (!done_v[idx] && lat < 40) begin
      if (busy_v[idx]) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_%0d", idx), lat, lat_of(idx));
    check($sformatf("busy_cycles_%0d", idx), busy_cnt, lat_of(idx));
    check($sformatf("busy_in_done_%0d", idx), busy_v[idx], 0);
    @(negedge clk);
    check($sformatf("done_width_%0d", idx), done_v[idx], 0);
  endtask

  task automatic wait_done0(inout int lat);
    while (!done_v[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int lat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rc;

    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start_v = '0;
    set_ops(1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy_%0d", i), busy_v[i], 0);
      check($sformatf("rst_done_%0d", i), done_v[i], 0);
      check($sformatf("rst_sum_%0d", i), sum_v[i], 0);
      check($sformatf("rst_cout_%0d", i), cout_v[i], 0);
      check($sformatf("rst_ovf_%0d", i), ovf_v[i], 0);
      check($sformatf("rst_state_%0d", i), dbg_v[i], 0);
    end

    // Directed add / subtract vectors on CHUNK=4: {sum, cout, ovf}
    run_op(0, 1'b0, 16'h1234, 16'h0FFF, 1'b0, {16'h2233, 1'b0, 1'b0});
    run_op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0});
    run_op(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1});
    run_op(0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, {16'h0000, 1'b1, 1'b0});
    run_op(0, 1'b1, 16'h0005, 16'h0007, 1'b0, {16'hFFFE, 1'b0, 1'b0});
    run_op(0, 1'b1, 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b1, 1'b1});
    run_op(0, 1'b1, 16'h0010, 16'h0001, 1'b1, {16'h000E, 1'b1, 1'b0});

    // start re-pulsed with new operands during RUN is ignored
    exp_q.push_back({2'd0, 16'h0300, 1'b0, 1'b0});
    set_ops(1'b0, 16'h0100, 16'h0200, 1'b0);
    start_v = 4'b0001;
    @(negedge clk);
    start_v = '0;
    @(negedge clk);
    set_ops(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    start_v = 4'b0001;
    @(negedge clk);
    start_v = '0;
    lat = 2;
    wait_done0(lat);
    check("repulse_latency", lat, 4);
    @(negedge clk);
    check("repulse_idle_after", busy_v[0], 0);

    // back-to-back: start presented in the done cycle
    exp_q.push_back({2'd0, 16'h0003, 1'b0, 1'b0});
    exp_q.push_back({2'd0, 16'h3333, 1'b0, 1'b0});
    set_ops(1'b0, 16'h0001, 16'h0002, 1'b0);
    start_v = 4'b0001;
    @(negedge clk);
    start_v = '0;
    lat = 0;
    wait_done0(lat);
    check("b2b_first_latency", lat, 4);
    set_ops(1'b0, 16'h1111, 16'h2222, 1'b0);
    start_v = 4'b0001;
    @(negedge clk);
    start_v = '0;
    check("b2b_busy_no_gap", busy_v[0], 1);
    lat = 0;
    wait_done0(lat);
    check("b2b_second_latency", lat, 4);
    @(negedge clk);

    // reset in the 2nd RUN cycle abandons the operation
    set_ops(1'b0, 16'h4321, 16'h1111, 1'b1);
    start_v = 4'b0001;
    @(negedge clk);
    start_v = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_busy", busy_v[0], 0);
    check("midrun_rst_done", done_v[0], 0);
    check("midrun_rst_sum", sum_v[0], 0);
    check("midrun_rst_cout", cout_v[0], 0);
    check("midrun_rst_ovf", ovf_v[0], 0);
    check("midrun_rst_state", dbg_v[0], 0);
    repeat (8) @(negedge clk);
    check("midrun_rst_still_idle", busy_v[0], 0);

    // reset and start together: stays IDLE
    set_ops(1'b0, 16'h0F0F, 16'h0101, 1'b0);
    rst = 1'b1;
    start_v = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    start_v = '0;
    check("rst_start_busy", busy_v[0], 0);
    check("rst_start_state", dbg_v[0], 0);
    @(negedge clk);
    check("rst_start_busy_later", busy_v[0], 0);

    // parameter sweep: same vectors on every CHUNK setting against the reference model
    for (int v = 0; v < 6; v++) begin
      case (v)
        0: begin ra = 16'h1234; rb = 16'h0FFF; rs = 1'b0; rc = 1'b0; end
        1: begin ra = 16'h7FFF; rb = 16'h0001; rs = 1'b0; rc = 1'b0; end
        2: begin ra = 16'h8000; rb = 16'h0001; rs = 1'b1; rc = 1'b0; end
        default: begin
          ra = 16'($urandom_range(0, 16'hFFFF));
          rb = 16'($urandom_range(0, 16'hFFFF));
          rs = 1'($urandom_range(0, 1));
          rc = 1'($urandom_range(0, 1));
        end
      endcase
      for (int i = 0; i < 4; i++) begin
        run_op(i, rs, ra, rb, rc, model(rs, ra, rb, rc));
      end
    end

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
